// File: rtl/tim_apb_arb_if.sv
// tim_apb_arb_if -- bus bundle for the timer APB arbiter.
//
// Carries both upstream APB3 requester ports (m0_*, m1_*) and the downstream
// APB2 timer slave port (s_*). Signal names match the arbiter's port list.
//
// Modports:
//   slave  : the arbiter's view. It samples the requesters and s_prdata, and
//            drives the requester responses and the timer slave bus.
//   master : the environment's view. It drives the requesters and the timer
//            read data, and observes everything else.
//
// Handshake: a requester raises psel with paddr/pwrite/pwdata stable and keeps
// them until it sees pready=1 on a rising pclk edge; pready is a one-cycle
// pulse and prdata is valid only in that cycle. The timer slave has no ready:
// each transfer is one SETUP cycle (psel=1, penable=0) followed by one ACCESS
// cycle (psel=1, penable=1), and s_prdata is taken in the ACCESS cycle.
interface tim_apb_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m0_psel;
  logic              m0_penable;
  logic [ADDR_W-1:0] m0_paddr;
  logic              m0_pwrite;
  logic [DATA_W-1:0] m0_pwdata;
  logic [DATA_W-1:0] m0_prdata;
  logic              m0_pready;

  logic              m1_psel;
  logic              m1_penable;
  logic [ADDR_W-1:0] m1_paddr;
  logic              m1_pwrite;
  logic [DATA_W-1:0] m1_pwdata;
  logic [DATA_W-1:0] m1_prdata;
  logic              m1_pready;

  logic              s_psel;
  logic              s_penable;
  logic [ADDR_W-1:0] s_paddr;
  logic              s_pwrite;
  logic [DATA_W-1:0] s_pwdata;
  logic [DATA_W-1:0] s_prdata;

  modport slave (
    input  m0_psel, m0_penable, m0_paddr, m0_pwrite, m0_pwdata,
    output m0_prdata, m0_pready,
    input  m1_psel, m1_penable, m1_paddr, m1_pwrite, m1_pwdata,
    output m1_prdata, m1_pready,
    output s_psel, s_penable, s_paddr, s_pwrite, s_pwdata,
    input  s_prdata
  );

  modport master (
    output m0_psel, m0_penable, m0_paddr, m0_pwrite, m0_pwdata,
    input  m0_prdata, m0_pready,
    output m1_psel, m1_penable, m1_paddr, m1_pwrite, m1_pwdata,
    input  m1_prdata, m1_pready,
    input  s_psel, s_penable, s_paddr, s_pwrite, s_pwdata,
    output s_prdata
  );
endinterface

// File: rtl/tim_apb_arb.sv
// tim_apb_arb -- two-requester APB arbiter in front of the timer APB slave.
//
// m0 (CPU APB bridge) and m1 (ETB / auto-reload sequencer) share the timer's
// single APB2 slave port. One downstream transfer takes three cycles:
// IDLE (arbitrate) -> SETUP -> ACCESS -> IDLE. Transfers are never split or
// interleaved; the grant is frozen from SETUP through ACCESS.
//
// Build option (macro TIM_APB_ARB_FIXED_PRIO_EN):
//   undefined : round-robin; on contention the master not served last wins,
//               the first contested grant after reset goes to m0.
//   defined   : fixed priority; m0 always wins, m1 is served only when
//               m0_psel is low in IDLE. The round-robin history is not built.
//
// Ports:
//   pclk        APB clock
//   presetn     asynchronous active-low reset
//   bus         tim_apb_arb_if.slave: m0_*/m1_* requesters, s_* timer slave
//   dbg_state   FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
//   dbg_grant   current grant register (0 = m0, 1 = m1)
//   dbg_penable granted requester's penable during ACCESS (protocol checker hook)
module tim_apb_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic          pclk,
  input  logic          presetn,
  tim_apb_arb_if.slave  bus,
  output logic [1:0]    dbg_state,
  output logic          dbg_grant,
  output logic          dbg_penable
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              grant;
  logic              win;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              busy;

  assign any_req = bus.m0_psel | bus.m1_psel;

`ifdef TIM_APB_ARB_FIXED_PRIO_EN
  // m0 wins whenever it asks.
  assign win = ~bus.m0_psel;
`else
  // last = master completed most recently; resets to m1 so that the first
  // contested grant goes to m0.
  logic last;
  assign win = (bus.m0_psel & bus.m1_psel) ? ~last : bus.m1_psel;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      state <= state_nxt;
      // Requests are only looked at in IDLE; anything arriving later waits.
      if (state == IDLE && any_req) grant <= win;
    end
  end

`ifndef TIM_APB_ARB_FIXED_PRIO_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)              last <= 1'b1;
    else if (state == ACCESS)  last <= grant;
  end
`endif

  assign busy = (state == SETUP) || (state == ACCESS);

  // Granted master's request fields; forced to zero when idle so the slave
  // bus does not follow requester activity between transfers.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    if (busy) begin
      sel_addr  = grant ? bus.m1_paddr  : bus.m0_paddr;
      sel_wdata = grant ? bus.m1_pwdata : bus.m0_pwdata;
      sel_write = grant ? bus.m1_pwrite : bus.m0_pwrite;
    end
  end

  always_comb begin
    bus.s_psel    = busy;
    bus.s_penable = (state == ACCESS);
    bus.s_paddr   = sel_addr;
    bus.s_pwdata  = sel_wdata;
    bus.s_pwrite  = sel_write;

    bus.m0_pready = 1'b0;
    bus.m1_pready = 1'b0;
    bus.m0_prdata = '0;
    bus.m1_prdata = '0;
    // Completion is a single-cycle pulse; read data passes straight through
    // from the timer since APB2 data is valid in the ACCESS cycle.
    if (state == ACCESS) begin
      if (grant) begin
        bus.m1_pready = 1'b1;
        bus.m1_prdata = bus.s_prdata;
      end else begin
        bus.m0_pready = 1'b1;
        bus.m0_prdata = bus.s_prdata;
      end
    end
  end

  assign dbg_state   = state;
  assign dbg_grant   = grant;
  assign dbg_penable = (state == ACCESS) && (grant ? bus.m1_penable : bus.m0_penable);

endmodule

// File: tb/tb_tim_apb_arb.sv
module tb_tim_apb_arb;

  logic       pclk;
  logic       presetn;
  logic [1:0] dbg_state;
  logic       dbg_grant;
  logic       dbg_penable;

  tim_apb_arb_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  tim_apb_arb #(.ADDR_W(8), .DATA_W(32)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_grant   (dbg_grant),
    .dbg_penable (dbg_penable)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Timer slave model: read data is a fixed function of the address.
  function automatic logic [31:0] rd_val(input logic [7:0] a);
    return {16'hCAFE, a, ~a};
  endfunction

  assign bus.s_prdata = rd_val(bus.s_paddr);

  // Expected transactions per requester: {pwrite, paddr, pwdata}.
  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];

  // ---------------- driver ----------------
  task automatic set_req(input int m, input logic sel, input logic en,
                         input logic [7:0] a, input logic w, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_psel = sel; bus.m0_penable = en; bus.m0_paddr = a;
      bus.m0_pwrite = w; bus.m0_pwdata = d;
    end else begin
      bus.m1_psel = sel; bus.m1_penable = en; bus.m1_paddr = a;
      bus.m1_pwrite = w; bus.m1_pwdata = d;
    end
  endtask

  // Called just after a rising edge. Returns after the edge that follows the
  // pready cycle, with psel already dropped; lat counts cycles from issue.
  task automatic do_txn(input int m, input logic [7:0] a, input logic w,
                        input logic [31:0] d, output int lat);
    logic done;
    done = 1'b0;
    lat  = 0;
    set_req(m, 1'b1, 1'b0, a, w, d);
    if (m == 0) exp_q0.push_back({w, a, d});
    else        exp_q1.push_back({w, a, d});
    while (!done && lat < 60) begin
      @(negedge pclk);
      if ((m == 0) ? bus.m0_pready : bus.m1_pready) done = 1'b1;
      else begin
        @(posedge pclk); #1;
        set_req(m, 1'b1, 1'b1, a, w, d);
        lat++;
      end
    end
    chk($sformatf("m%0d_completed", m), 32'(done), 32'd1);
    @(posedge pclk); #1;
    set_req(m, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   mon_phase = 0;   // 0 idle, 1 setup, 2 access as observed
  int   last_served = 1; // reference history: m1 counts as served at reset
  int   cur_w = 0;
  int   exp_w;
  int   p0_cnt = 0;
  int   p1_cnt = 0;
  logic req0_prev = 1'b0;
  logic req1_prev = 1'b0;
  logic [40:0] fr;
  logic have;

  initial begin
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        chk("rst_s_psel", 32'(bus.s_psel), 32'd0);
        chk("rst_s_penable", 32'(bus.s_penable), 32'd0);
        chk("rst_m0_pready", 32'(bus.m0_pready), 32'd0);
        chk("rst_m1_pready", 32'(bus.m1_pready), 32'd0);
        last_served = 1;
        mon_phase   = 0;
      end else if (!bus.s_psel) begin
        chk("idle_s_penable", 32'(bus.s_penable), 32'd0);
        chk("idle_s_paddr", 32'(bus.s_paddr), 32'd0);
        chk("idle_s_pwdata", bus.s_pwdata, 32'd0);
        chk("idle_s_pwrite", 32'(bus.s_pwrite), 32'd0);
        chk("idle_m0_pready", 32'(bus.m0_pready), 32'd0);
        chk("idle_m1_pready", 32'(bus.m1_pready), 32'd0);
        chk("idle_m0_prdata", bus.m0_prdata, 32'd0);
        chk("idle_m1_prdata", bus.m1_prdata, 32'd0);
        mon_phase = 0;
      end else if (!bus.s_penable) begin
        chk("setup_follows_idle", 32'(mon_phase), 32'd0);
        chk("setup_had_request", 32'(req0_prev | req1_prev), 32'd1);
`ifdef TIM_APB_ARB_FIXED_PRIO_EN
        exp_w = req0_prev ? 0 : 1;
`else
        exp_w = (req0_prev && req1_prev) ? (1 - last_served) : (req0_prev ? 0 : 1);
`endif
        cur_w = exp_w;
        have = (exp_w == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        chk($sformatf("setup_m%0d_pending", exp_w), 32'(have), 32'd1);
        if (have) begin
          fr = (exp_w == 0) ? exp_q0[0] : exp_q1[0];
          chk($sformatf("setup_m%0d_paddr", exp_w), 32'(bus.s_paddr), 32'(fr[39:32]));
          chk($sformatf("setup_m%0d_pwrite", exp_w), 32'(bus.s_pwrite), 32'(fr[40]));
          chk($sformatf("setup_m%0d_pwdata", exp_w), bus.s_pwdata, fr[31:0]);
        end
        chk("setup_m0_pready", 32'(bus.m0_pready), 32'd0);
        chk("setup_m1_pready", 32'(bus.m1_pready), 32'd0);
        mon_phase = 1;
      end else begin
        chk("access_follows_setup", 32'(mon_phase), 32'd1);
        have = (cur_w == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        if (have) begin
          fr = (cur_w == 0) ? exp_q0[0] : exp_q1[0];
          chk("access_paddr", 32'(bus.s_paddr), 32'(fr[39:32]));
          chk("access_pwdata", bus.s_pwdata, fr[31:0]);
          if (cur_w == 0) begin
            chk("access_m0_pready", 32'(bus.m0_pready), 32'd1);
            chk("access_m1_pready_idle", 32'(bus.m1_pready), 32'd0);
            chk("access_m0_prdata", bus.m0_prdata, rd_val(fr[39:32]));
            chk("access_m1_prdata_zero", bus.m1_prdata, 32'd0);
            void'(exp_q0.pop_front());
          end else begin
            chk("access_m1_pready", 32'(bus.m1_pready), 32'd1);
            chk("access_m0_pready_idle", 32'(bus.m0_pready), 32'd0);
            chk("access_m1_prdata", bus.m1_prdata, rd_val(fr[39:32]));
            chk("access_m0_prdata_zero", bus.m0_prdata, 32'd0);
            void'(exp_q1.pop_front());
          end
        end
        last_served = cur_w;
        mon_phase = 2;
      end
      if (presetn && bus.m0_pready) p0_cnt++;
      if (presetn && bus.m1_pready) p1_cnt++;
      req0_prev = bus.m0_psel;
      req1_prev = bus.m1_psel;
    end
  end

  // ---------------- stimulus ----------------
  int l0, l1, p0_before, exp_m1_lat;
  logic [7:0]  ra0, ra1;
  logic [31:0] rd0, rd1;
  logic        rw0, rw1;

  initial begin
    presetn = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;

    // 1: lone m0 write
    do_txn(0, 8'h04, 1'b1, 32'h0000_1234, l0);
    chk("t1_m0_latency", 32'(l0), 32'd2);

    // 2: lone m1 read
    do_txn(1, 8'h10, 1'b0, 32'h0, l1);
    chk("t2_m1_latency", 32'(l1), 32'd2);

    // 3: both request in the same cycle, each twice back to back
`ifdef TIM_APB_ARB_FIXED_PRIO_EN
    exp_m1_lat = 8;
`else
    exp_m1_lat = 5;
`endif
    fork
      begin
        do_txn(0, 8'h20, 1'b1, 32'hA0A0_0001, l0);
        chk("t3_m0_first_latency", 32'(l0), 32'd2);
        do_txn(0, 8'h21, 1'b0, 32'h0, l0);
      end
      begin
        do_txn(1, 8'h30, 1'b1, 32'hB1B1_0002, l1);
        chk("t3_m1_first_latency", 32'(l1), 32'(exp_m1_lat));
        do_txn(1, 8'h31, 1'b0, 32'h0, l1);
      end
    join

    // 4: m0 hammering while m1 waits
    fork
      begin
        for (int i = 0; i < 4; i++) do_txn(0, 8'(8'h40 + i), 1'b1, 32'(i), l0);
      end
      begin
        do_txn(1, 8'h50, 1'b1, 32'h5555_5555, l1);
      end
    join

    // 5: reset during SETUP of an m1 request; the request survives it
    fork
      do_txn(1, 8'h60, 1'b1, 32'h6666_0006, l1);
      begin
        for (int i = 0; i < 10 && !(presetn && bus.s_psel && !bus.s_penable); i++)
          @(negedge pclk);
        chk("t5_reached_setup", 32'(bus.s_psel), 32'd1);
        #1 presetn = 1'b0;
        #1;
        chk("t5_s_psel_drop", 32'(bus.s_psel), 32'd0);
        chk("t5_s_penable_drop", 32'(bus.s_penable), 32'd0);
        chk("t5_m1_pready_drop", 32'(bus.m1_pready), 32'd0);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        presetn = 1'b1;
      end
    join

    // 6: m0 drops psel during SETUP; m1 arrives meanwhile
    p0_before = p0_cnt;
    set_req(0, 1'b1, 1'b0, 8'h70, 1'b1, 32'h7777_0007);
    exp_q0.push_back({1'b1, 8'h70, 32'h7777_0007});
    @(posedge pclk); #1;
    bus.m0_psel = 1'b0;
    do_txn(1, 8'h71, 1'b0, 32'h0, l1);
    chk("t6_m1_latency", 32'(l1), 32'd4);
    chk("t6_m0_single_pulse", 32'(p0_cnt - p0_before), 32'd1);
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);

    // random traffic from both requesters
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra0 = 8'($urandom_range(0, 255));
          rw0 = 1'($urandom_range(0, 1));
          rd0 = $urandom;
          do_txn(0, ra0, rw0, rd0, l0);
          chk("rnd_m0_lat_min", 32'(l0 >= 2), 32'd1);
`ifndef TIM_APB_ARB_FIXED_PRIO_EN
          chk("rnd_m0_lat_max", 32'(l0 <= 5), 32'd1);
`endif
          repeat ($urandom_range(1, 3)) begin @(posedge pclk); #1; end
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          ra1 = 8'($urandom_range(0, 255));
          rw1 = 1'($urandom_range(0, 1));
          rd1 = $urandom;
          do_txn(1, ra1, rw1, rd1, l1);
          chk("rnd_m1_lat_min", 32'(l1 >= 2), 32'd1);
`ifndef TIM_APB_ARB_FIXED_PRIO_EN
          chk("rnd_m1_lat_max", 32'(l1 <= 5), 32'd1);
`endif
          repeat ($urandom_range(0, 2)) begin @(posedge pclk); #1; end
        end
      end
    join

    repeat (5) @(posedge pclk);
    chk("end_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("end_q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
